// File: rtl/legv8_imm_pkg.sv
// Shared types and opcode constants for the LEGv8 immediate generator.
package legv8_imm_pkg;

    // Instruction format decoded from the opcode field
    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_D    = 3'd1,
        FMT_CB   = 3'd2,
        FMT_B    = 3'd3,
        FMT_I    = 3'd4,
        FMT_IW   = 3'd5
    } fmt_t;

    // Opcodes, each sized to the field they are matched against
    localparam logic [10:0] OP_LDUR = 11'h7C2;  // instr[31:21]
    localparam logic [10:0] OP_STUR = 11'h7C0;  // instr[31:21]
    localparam logic [7:0]  OP_CBZ  = 8'hB4;    // instr[31:24]
    localparam logic [7:0]  OP_CBNZ = 8'hB5;    // instr[31:24]
    localparam logic [5:0]  OP_B    = 6'h05;    // instr[31:26]
    localparam logic [5:0]  OP_BL   = 6'h25;    // instr[31:26]
    localparam logic [9:0]  OP_ADDI = 10'h244;  // instr[31:22]
    localparam logic [9:0]  OP_SUBI = 10'h344;  // instr[31:22]
    localparam logic [8:0]  OP_MOVZ = 9'h1A5;   // instr[31:23]

    // Widest supported immediate; narrower builds use the low bits only
    localparam int IMM_W_MAX = 64;

    // What one pipeline stage carries
    typedef struct packed {
        logic [IMM_W_MAX-1:0] imm;
        fmt_t                 fmt;
        logic                 illegal;
    } payload_t;

endpackage

// File: rtl/imm_decode.sv
// Combinational LEGv8 immediate decoder: picks the format from the opcode,
// extracts the immediate field and sign/zero-extends it to N bits.
module imm_decode
    import legv8_imm_pkg::*;
#(
    parameter int N = 64
) (
    input  logic [31:0]  instr,
    output logic [N-1:0] imm,
    output fmt_t         fmt,
    output logic         illegal
);

    // MOVZ shift amount in bits (16 * hw), wide enough to compare against N
    logic [6:0]   iw_shift;
    logic [N-1:0] iw_field;

    assign iw_shift = {1'b0, instr[22:21], 4'b0000};
    assign iw_field = N'(instr[20:5]);

    // Priority opcode match; branch offsets stay in instruction units
    always_comb begin
        imm     = '0;
        fmt     = FMT_NONE;
        illegal = 1'b0;
        if (instr[31:21] == OP_LDUR || instr[31:21] == OP_STUR) begin
            fmt = FMT_D;
            imm = {{(N-9){instr[20]}}, instr[20:12]};
        end else if (instr[31:24] == OP_CBZ || instr[31:24] == OP_CBNZ) begin
            fmt = FMT_CB;
            imm = {{(N-19){instr[23]}}, instr[23:5]};
        end else if (instr[31:26] == OP_B || instr[31:26] == OP_BL) begin
            fmt = FMT_B;
            imm = {{(N-26){instr[25]}}, instr[25:0]};
        end else if (instr[31:22] == OP_ADDI || instr[31:22] == OP_SUBI) begin
            fmt = FMT_I;
            imm = N'(instr[21:10]);
        end else if (instr[31:23] == OP_MOVZ) begin
            fmt = FMT_IW;
            // A halfword slot beyond the result width cannot be represented
            if (iw_shift >= 7'(N)) begin
                illegal = 1'b1;
            end else begin
                imm = iw_field << iw_shift;
            end
        end else begin
            illegal = 1'b1;
        end
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined LEGv8 immediate generator: decode once, then carry the result
// through STAGES valid/ready registers with a synchronous flush.
module imm_gen_pipe
    import legv8_imm_pkg::*;
#(
    parameter int N      = 64,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  instr,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] imm,
    output fmt_t         fmt,
    output logic         illegal
);

    logic [N-1:0] dec_imm;
    fmt_t         dec_fmt;
    logic         dec_illegal;
    payload_t     dec_payload;

    logic [STAGES-1:0] v;
    logic [STAGES-1:0] mv;
    payload_t          stage_data [STAGES];

    imm_decode #(.N(N)) u_decode (
        .instr   (instr),
        .imm     (dec_imm),
        .fmt     (dec_fmt),
        .illegal (dec_illegal)
    );

    assign dec_payload.imm     = IMM_W_MAX'(dec_imm);
    assign dec_payload.fmt     = dec_fmt;
    assign dec_payload.illegal = dec_illegal;

    // Move signals, resolved from the output back toward the input so a full
    // pipeline can still advance while the consumer accepts
    always_comb begin
        mv = '0;
        mv[STAGES-1] = v[STAGES-1] && out_ready;
        for (int k = STAGES - 2; k >= 0; k--) begin
            mv[k] = v[k] && (!v[k+1] || mv[k+1]);
        end
    end

    // Combinational from out_ready through the move chain; no skid buffer
    assign in_ready = !v[0] || mv[0];

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
            logic     v_reg;
            logic     load;
            payload_t data_reg;
            payload_t src;

            if (gi == 0) begin : g_first
                assign load = in_valid && in_ready;
                assign src  = dec_payload;
            end else begin : g_chain
                assign load = mv[gi-1];
                assign src  = stage_data[gi-1];
            end

            // Occupancy: flush empties every stage, otherwise fill/drain
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    v_reg <= 1'b0;
                end else if (flush) begin
                    v_reg <= 1'b0;
                end else if (load) begin
                    v_reg <= 1'b1;
                end else if (mv[gi]) begin
                    v_reg <= 1'b0;
                end
            end

            // Payload: only the output stage is scrubbed on flush so the
            // visible outputs return to their idle values
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    data_reg <= '0;
                end else if (flush && gi == STAGES - 1) begin
                    data_reg <= '0;
                end else if (load) begin
                    data_reg <= src;
                end
            end

            assign v[gi]          = v_reg;
            assign stage_data[gi] = data_reg;
        end

        if (N < IMM_W_MAX) begin : g_trim
            logic unused_hi;
            assign unused_hi = ^stage_data[STAGES-1].imm[IMM_W_MAX-1:N];
        end
    endgenerate

    assign out_valid = v[STAGES-1];
    assign imm       = stage_data[STAGES-1].imm[N-1:0];
    assign fmt       = stage_data[STAGES-1].fmt;
    assign illegal   = stage_data[STAGES-1].illegal;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: a 64-bit 2-stage instance exercised for
// handshake behaviour and a 32-bit 1-stage instance fed the same words.
module tb_imm_gen_pipe;

    localparam int S1 = 2;
    localparam int S2 = 1;

    typedef struct {
        logic [31:0] w;
        logic [63:0] i64;
        logic [2:0]  f64;
        logic        l64;
        logic [31:0] i32;
        logic [2:0]  f32;
        logic        l32;
    } vec_t;

    typedef struct {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
        int          t;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic [31:0] instr;
    logic        out_ready;
    logic        in_ready1, out_valid1, illegal1;
    logic [63:0] imm1;
    logic [2:0]  fmt1;
    logic        flush2 = 1'b0;
    logic        out_ready2 = 1'b1;
    logic        in_ready2, out_valid2, illegal2;
    logic [31:0] imm2;
    logic [2:0]  fmt2;

    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    bit   lat_check = 1'b0;
    bit   rand_rdy = 1'b0;
    vec_t cur;
    vec_t vecs [14];
    exp_t q1 [$];
    exp_t q2 [$];

    always #5 clk = ~clk;

    imm_gen_pipe #(.N(64), .STAGES(S1)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready1), .instr(instr),
        .out_valid(out_valid1), .out_ready(out_ready),
        .imm(imm1), .fmt(fmt1), .illegal(illegal1)
    );

    imm_gen_pipe #(.N(32), .STAGES(S2)) dut32 (
        .clk(clk), .reset(reset), .flush(flush2),
        .in_valid(in_valid), .in_ready(in_ready2), .instr(instr),
        .out_valid(out_valid2), .out_ready(out_ready2),
        .imm(imm2), .fmt(fmt2), .illegal(illegal2)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    end

    // Handshakes seen here complete at the next rising edge
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            q1.delete();
            q2.delete();
        end else begin
            if (out_valid1 && out_ready) begin
                check("sb_nonempty64", 64'(q1.size() != 0), 64'd1);
                if (q1.size() != 0) begin
                    e = q1.pop_front();
                    $display("[%0t] dut64 out imm=0x%0h fmt=%0d ill=%0b", $time, imm1, fmt1, illegal1);
                    check("imm64", imm1, e.imm);
                    check("fmt64", 64'(fmt1), 64'(e.fmt));
                    check("ill64", 64'(illegal1), 64'(e.ill));
                    if (lat_check) check("lat64", 64'(cyc - e.t), 64'(S1 - 1));
                end
            end
            if (flush) begin
                q1.delete();
            end else if (in_valid && in_ready1) begin
                e = '{imm: cur.i64, fmt: cur.f64, ill: cur.l64, t: cyc + 1};
                q1.push_back(e);
            end
            if (out_valid2 && out_ready2) begin
                check("sb_nonempty32", 64'(q2.size() != 0), 64'd1);
                if (q2.size() != 0) begin
                    e = q2.pop_front();
                    $display("[%0t] dut32 out imm=0x%0h fmt=%0d ill=%0b", $time, imm2, fmt2, illegal2);
                    check("imm32", 64'(imm2), e.imm);
                    check("fmt32", 64'(fmt2), 64'(e.fmt));
                    check("ill32", 64'(illegal2), 64'(e.ill));
                    if (lat_check) check("lat32", 64'(cyc - e.t), 64'(S2 - 1));
                end
            end
            if (flush2) begin
                q2.delete();
            end else if (in_valid && in_ready2) begin
                e = '{imm: 64'(cur.i32), fmt: cur.f32, ill: cur.l32, t: cyc + 1};
                q2.push_back(e);
            end
        end
    end

    // Present one word and hold it until the 64-bit instance accepts it
    task automatic send(input vec_t v);
        bit ok;
        ok = 1'b0;
        cur = v;
        instr = v.w;
        in_valid = 1'b1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (in_ready1) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!ok) check("send_timeout", 64'(in_ready1), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{32'hf8408041, 64'h8,                  3'd1, 1'b0, 32'h8,        3'd1, 1'b0};
        vecs[1]  = '{32'hf85f8041, 64'hffff_ffff_ffff_fff8, 3'd1, 1'b0, 32'hffff_fff8, 3'd1, 1'b0};
        vecs[2]  = '{32'hb4000021, 64'h1,                  3'd2, 1'b0, 32'h1,        3'd2, 1'b0};
        vecs[3]  = '{32'hb4fff801, 64'hffff_ffff_ffff_ffc0, 3'd2, 1'b0, 32'hffff_ffc0, 3'd2, 1'b0};
        vecs[4]  = '{32'h17ffffff, 64'hffff_ffff_ffff_ffff, 3'd3, 1'b0, 32'hffff_ffff, 3'd3, 1'b0};
        vecs[5]  = '{32'h913ffc21, 64'h0fff,               3'd4, 1'b0, 32'h0fff,     3'd4, 1'b0};
        vecs[6]  = '{32'hd2a00021, 64'h1_0000,             3'd5, 1'b0, 32'h1_0000,   3'd5, 1'b0};
        vecs[7]  = '{32'hd2e00021, 64'h0001_0000_0000_0000, 3'd5, 1'b0, 32'h0,        3'd5, 1'b1};
        vecs[8]  = '{32'h00000000, 64'h0,                  3'd0, 1'b1, 32'h0,        3'd0, 1'b1};
        vecs[9]  = '{32'hd2c00021, 64'h0000_0001_0000_0000, 3'd5, 1'b0, 32'h0,        3'd5, 1'b1};
        vecs[10] = '{32'hb5000041, 64'h2,                  3'd2, 1'b0, 32'h2,        3'd2, 1'b0};
        vecs[11] = '{32'hf81f0000, 64'hffff_ffff_ffff_fff0, 3'd1, 1'b0, 32'hffff_fff0, 3'd1, 1'b0};
        vecs[12] = '{32'h94000003, 64'h3,                  3'd3, 1'b0, 32'h3,        3'd3, 1'b0};
        vecs[13] = '{32'hd1000421, 64'h1,                  3'd4, 1'b0, 32'h1,        3'd4, 1'b0};

        reset = 1'b1;
        flush = 1'b0;
        in_valid = 1'b0;
        instr = '0;
        out_ready = 1'b1;
        cur = vecs[8];

        // Reset state
        #2;
        check("rst_out_valid", 64'(out_valid1), 64'd0);
        check("rst_imm", imm1, 64'd0);
        check("rst_fmt", 64'(fmt1), 64'd0);
        check("rst_illegal", 64'(illegal1), 64'd0);
        check("rst_out_valid32", 64'(out_valid2), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready1), 64'd1);
        @(posedge clk);
        #1;

        // Back-to-back stream, exact latency and full throughput
        lat_check = 1'b1;
        for (int i = 0; i < 14; i++) send(vecs[i]);
        idle(4);
        lat_check = 1'b0;

        // Backpressure: two fill the pipe, the third waits
        out_ready = 1'b0;
        send(vecs[0]);
        send(vecs[3]);
        cur = vecs[4];
        instr = vecs[4].w;
        in_valid = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("stall_in_ready", 64'(in_ready1), 64'd0);
            check("stall_out_valid", 64'(out_valid1), 64'd1);
            check("stall_imm", imm1, vecs[0].i64);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("release_in_ready", 64'(in_ready1), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        idle(4);

        // Random consumer readiness must not lose or reorder results
        rand_rdy = 1'b1;
        for (int i = 0; i < 20; i++) send(vecs[(i * 5) % 14]);
        rand_rdy = 1'b0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        idle(5);

        // Flush with two in flight, plus a concurrent offer and drain
        out_ready = 1'b0;
        send(vecs[1]);
        send(vecs[2]);
        out_ready = 1'b1;
        flush = 1'b1;
        cur = vecs[5];
        instr = vecs[5].w;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("flush_out_valid", 64'(out_valid1), 64'd0);
            @(posedge clk);
            #1;
        end
        lat_check = 1'b1;
        send(vecs[6]);
        idle(3);
        lat_check = 1'b0;

        // Asynchronous reset in mid-stream
        send(vecs[10]);
        send(vecs[11]);
        #2;
        reset = 1'b1;
        #1;
        check("arst_out_valid", 64'(out_valid1), 64'd0);
        check("arst_imm", imm1, 64'd0);
        check("arst_fmt", 64'(fmt1), 64'd0);
        check("arst_out_valid32", 64'(out_valid2), 64'd0);
        @(posedge clk);
        #3;
        reset = 1'b0;
        @(negedge clk);
        check("arst_in_ready", 64'(in_ready1), 64'd1);
        check("arst_idle_valid", 64'(out_valid1), 64'd0);
        @(posedge clk);
        #1;
        lat_check = 1'b1;
        send(vecs[12]);
        send(vecs[13]);
        idle(4);
        lat_check = 1'b0;

        check("sb_drain64", 64'(q1.size()), 64'd0);
        check("sb_drain32", 64'(q2.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
